credit_switch_allocator: RTL
============================

# credit_switch_allocator

Credit-based switch allocator for the mesh router. It sits between the per-input route calculators and the one-hot switch, in place of enable-based flow control. It arbitrates the N inputs onto the M outputs with a round-robin pointer per output. It grants an output only while a credit counter shows free space in the downstream input queue.

## Interface
Parameters:
- CREDITS, default `INPUT_QUEUE_DEPTH: downstream queue slots per output; reset value of every credit counter.
- CW, default $clog2(CREDITS+1): credit counter width, derived; do not override.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  clock enable; low freezes grants and pointers.
- i_output_req  in  [0:`N-1][0:`M-1]  per-input request word from the route calculators; at most one bit set per input.
- i_credit_return  in  [0:`M-1]  one-cycle pulse from downstream; one queue slot freed.
- o_output_grant  out  [0:`M-1][0:`N-1]  per-output one-hot select to the switch; drives o_data_val.
- o_input_grant  out  [0:`N-1]  dequeue enable to each input FIFO.
- o_credit_count  out  [0:`M-1][CW-1:0]  current credit counters, for observability.
- o_credit_err  out  1  sticky flag for credit overflow.

## Operation
- Eligibility: output m is eligible when ce=1, reset=0 and credit[m] > 0.
- Arbitration: an eligible output m grants one requester i (i_output_req[i][m]=1).
  - Search starts at ptr[m] and increments modulo N.
  - The first requester found wins.
- Input grant: o_input_grant[i] = OR over m of o_output_grant[m][i]. Exactly one-hot or zero, because each input requests at most one output.
- Pointer update: when output m grants input i, ptr[m] ← (i+1) mod N. When output m grants nothing, ptr[m] holds.
- Credit update, every edge, including ce=0 cycles: credit[m] ← credit[m] − grant_any[m] + i_credit_return[m].
  - Grant and return in the same cycle: the count is unchanged.
- Overflow: a return arriving with credit[m]=CREDITS and no grant that cycle:
  - the counter saturates at CREDITS;
  - o_credit_err sets and stays set until reset.
- Underflow cannot occur: no grant is issued at credit 0.
- ce=0:
  - all grants are 0 and pointers hold;
  - credit returns are still absorbed, because they originate downstream and are independent of the local ce.

## Timing
- Grants are combinational from i_output_req, credit and ptr: zero-cycle request-to-grant.
  - The FIFO dequeues at the same edge the switch output is registered downstream.
- Counter and pointer changes become visible the cycle after the grant or return edge.
- A grant at credit=1 leaves credit=0. The next cycle gives no grant on that output unless a return arrives (see Configuration).
- Reset (sampled high at an edge, including mid-operation):
  - credit ← CREDITS, ptr ← 0, o_credit_err ← 0;
  - o_output_grant and o_input_grant are forced 0 combinationally while reset is high;
  - o_credit_count shows CREDITS from the first post-reset cycle;
  - any in-flight packet is considered dropped; downstream is reset together with this block.

## Configuration
- CREDIT_BYPASS_EN defined:
  - output m is also eligible at credit[m]=0 when i_credit_return[m]=1 in the same cycle;
  - the returned credit is consumed immediately and the counter stays 0.
- Not defined:
  - eligibility uses only the registered credit[m] > 0;
  - a return at zero credit allows a grant one cycle later.

## Structure
- Shared package, already holding `N, `M and packet_t: add a typedef for the credit counter (credit_t, CW bits) and the CREDITS default constant.
- Sub-module rr_arbiter, instantiated M times. It contains:
  - N-bit request in, N-bit one-hot grant out;
  - enable input;
  - its own pointer register, with clk, ce and reset.
- The top level holds the credit counters, the input-grant OR and the error flag.

## Test plan
(N=M=5, CREDITS=4 unless noted.)
- Reset: hold reset 2 cycles with all requests high.
  - Grants are 0 throughout.
  - After release, o_credit_count = 4 on all outputs; o_credit_err = 0.
- Round-robin: inputs 0, 2 and 4 request output 1 continuously; a return arrives every cycle.
  - Grants on output 1 cycle through inputs 0, 2, 4, 0, …
  - o_input_grant matches the granted input each cycle.
- Credit exhaustion: input 3 requests output 2 with no returns.
  - Exactly 4 consecutive grants, then credit 0 and no grant.
  - One return pulse leads to one more grant: next cycle without CREDIT_BYPASS_EN, same cycle with it.
- Simultaneous grant and return at credit 2: credit stays 2.
- Overflow: a return at credit 4 with no request.
  - Count stays 4 and o_credit_err sets.
  - A later reset clears o_credit_err.
- ce low: requests present and returns pulsed while ce=0.
  - No grants and pointers frozen; credits increment, saturating at CREDITS.
  - When ce rises, arbitration resumes from the frozen pointer.

Source files
------------

// File: rtl/credit_switch_allocator_pkg.sv
// Shared router types: dimensions, packet format and the credit counter type.
// CREDIT_BYPASS_EN (optional, off by default) lets a same-cycle credit return unlock a grant at zero credit.
`ifndef N
`define N 5
`endif
`ifndef M
`define M 5
`endif
`ifndef INPUT_QUEUE_DEPTH
`define INPUT_QUEUE_DEPTH 4
`endif

package credit_switch_allocator_pkg;
    localparam int N_IN        = `N;
    localparam int M_OUT       = `M;
    localparam int CREDITS_DEF = `INPUT_QUEUE_DEPTH;
    localparam int CW          = $clog2(CREDITS_DEF + 1);

    typedef logic [CW-1:0] credit_t;

    typedef struct packed {
        logic [$clog2(`M)-1:0] dest;
        logic [31:0]           payload;
    } packet_t;
endpackage

// File: rtl/credit_switch_allocator_if.sv
// Request/grant/credit bundle between the route calculators, the allocator and the switch.
interface credit_switch_allocator_if
    import credit_switch_allocator_pkg::*;
#(
    parameter int CW = credit_switch_allocator_pkg::CW
);
    logic [0:`N-1][0:`M-1] i_output_req;
    logic [0:`M-1]         i_credit_return;
    logic [0:`M-1][0:`N-1] o_output_grant;
    logic [0:`N-1]         o_input_grant;
    logic [0:`M-1][CW-1:0] o_credit_count;
    logic                  o_credit_err;

    modport master (
        output i_output_req, i_credit_return,
        input  o_output_grant, o_input_grant, o_credit_count, o_credit_err
    );

    modport slave (
        input  i_output_req, i_credit_return,
        output o_output_grant, o_input_grant, o_credit_count, o_credit_err
    );
endinterface

// File: rtl/credit_switch_allocator_rr_arbiter.sv
// Round-robin arbiter for one switch output: combinational one-hot grant, pointer advances past the winner.
module rr_arbiter
    import credit_switch_allocator_pkg::*;
#(
    parameter int N = `N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ce,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    typedef logic [PW-1:0] ptr_t;

    ptr_t ptr;
    ptr_t next_ptr;
    logic found;

    function automatic ptr_t wrap(ptr_t p, int k);
        int s;
        s = int'(p) + k;
        if (s >= N) s = s - N;
        return ptr_t'(s);
    endfunction

    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && en && req[wrap(ptr, k)]) begin
                grant[wrap(ptr, k)] = 1'b1;
                next_ptr            = wrap(wrap(ptr, k), 1);
                found               = 1'b1;
            end
        end
    end

    // Grants only exist when en is high, and en already folds in ce and reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (ce && found) begin
            ptr <= next_ptr;
        end
    end
endmodule

// File: rtl/credit_switch_allocator.sv
// Credit-based switch allocator: per-output round-robin arbitration gated by downstream queue credits.
// Optional CREDIT_BYPASS_EN: an output at zero credit may grant when a credit returns in the same cycle.
module credit_switch_allocator
    import credit_switch_allocator_pkg::*;
#(
    parameter int CREDITS = `INPUT_QUEUE_DEPTH,
    parameter int CW      = $clog2(CREDITS + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ce,
    credit_switch_allocator_if.slave   bus
);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);
    localparam logic [CW-1:0] CREDIT_ONE = CW'(1);

    logic [CW-1:0]         credit [`M];
    logic                  err;
    logic [`M-1:0]         eligible;
    logic [`M-1:0]         grant_any;
    logic [`N-1:0]         req_col   [`M];
    logic [`N-1:0]         grant_col [`M];

    always_comb begin
        for (int m = 0; m < `M; m++) begin
            for (int i = 0; i < `N; i++) begin
                req_col[m][i] = bus.i_output_req[i][m];
            end
`ifdef CREDIT_BYPASS_EN
            eligible[m] = ce && !reset && ((credit[m] != '0) || bus.i_credit_return[m]);
`else
            eligible[m] = ce && !reset && (credit[m] != '0);
`endif
        end
    end

    for (genvar m = 0; m < `M; m++) begin : g_arb
        rr_arbiter #(.N(`N)) u_arb (
            .clk   (clk),
            .reset (reset),
            .ce    (ce),
            .en    (eligible[m]),
            .req   (req_col[m]),
            .grant (grant_col[m])
        );
    end

    always_comb begin
        bus.o_input_grant = '0;
        for (int m = 0; m < `M; m++) begin
            grant_any[m] = |grant_col[m];
            for (int i = 0; i < `N; i++) begin
                bus.o_output_grant[m][i] = grant_col[m][i];
                bus.o_input_grant[i]     = bus.o_input_grant[i] | grant_col[m][i];
            end
            bus.o_credit_count[m] = credit[m];
        end
        bus.o_credit_err = err;
    end

    // Returns are absorbed regardless of ce; a grant and return in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int m = 0; m < `M; m++) credit[m] <= CREDIT_MAX;
            err <= 1'b0;
        end else begin
            for (int m = 0; m < `M; m++) begin
                if (grant_any[m] && !bus.i_credit_return[m]) begin
                    credit[m] <= credit[m] - CREDIT_ONE;
                end else if (!grant_any[m] && bus.i_credit_return[m]) begin
                    if (credit[m] == CREDIT_MAX) err <= 1'b1;
                    else                         credit[m] <= credit[m] + CREDIT_ONE;
                end
            end
        end
    end
endmodule
